// File: rtl/aes_inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one shared column datapath, one column per cycle.
// Define AES_MIX_FWD_EN to add the inForward port and the forward MixColumns path.
module aes_inv_mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] inData,
    input  logic         inValid,
`ifdef AES_MIX_FWD_EN
    input  logic         inForward,
`endif
    output logic         inReady,
    output logic [127:0] outData,
    output logic         outValid,
    input  logic         outReady
);

    // state | meaning
    // IDLE  | waiting for inValid, inReady=1
    // BUSY  | transforming column cnt_q, one per cycle
    // DONE  | result held on outData until outReady
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q;
    logic [127:0] st_q;
    logic [31:0]  col_in, col_out;
    logic         accept;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mule(a1) ^ mulb(a2) ^ muld(a3) ^ mul9(a0),
                mule(a2) ^ mulb(a3) ^ muld(a0) ^ mul9(a1),
                mule(a3) ^ mulb(a0) ^ muld(a1) ^ mul9(a2)};
    endfunction

`ifdef AES_MIX_FWD_EN
    logic fwd_q;

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                xt(a1) ^ xt(a2) ^ a2 ^ a3 ^ a0,
                xt(a2) ^ xt(a3) ^ a3 ^ a0 ^ a1,
                xt(a3) ^ xt(a0) ^ a0 ^ a1 ^ a2};
    endfunction
`endif

    always_comb begin
        col_in = st_q[127:96];
        case (cnt_q)
            2'd0: col_in = st_q[127:96];
            2'd1: col_in = st_q[95:64];
            2'd2: col_in = st_q[63:32];
            2'd3: col_in = st_q[31:0];
            default: col_in = st_q[127:96];
        endcase
`ifdef AES_MIX_FWD_EN
        col_out = fwd_q ? fwd_col(col_in) : inv_col(col_in);
`else
        col_out = inv_col(col_in);
`endif
    end

    always_comb begin
        state_d  = state_q;
        inReady  = 1'b0;
        outValid = 1'b0;
        case (state_q)
            IDLE: begin
                inReady = !rst;
                if (inValid && !rst) state_d = BUSY;
            end
            BUSY: begin
                if (cnt_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                outValid = !rst;
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept  = inReady && inValid;
    assign outData = st_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            st_q    <= 128'd0;
`ifdef AES_MIX_FWD_EN
            fwd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                st_q  <= inData;
                cnt_q <= 2'd0;
`ifdef AES_MIX_FWD_EN
                fwd_q <= inForward;
`endif
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 2'd1;
                case (cnt_q)
                    2'd0: st_q[127:96] <= col_out;
                    2'd1: st_q[95:64]  <= col_out;
                    2'd2: st_q[63:32]  <= col_out;
                    2'd3: st_q[31:0]   <= col_out;
                    default: st_q[127:96] <= col_out;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_mix_columns_seq.sv
// Randomized bench for aes_inv_mix_columns_seq against a generic GF(2^8) matrix model.
module tb_aes_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] inData;
    logic         inValid;
    logic         inReady;
    logic [127:0] outData;
    logic         outValid;
    logic         outReady;
`ifdef AES_MIX_FWD_EN
    logic         inForward;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    aes_inv_mix_columns_seq dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .inValid  (inValid),
`ifdef AES_MIX_FWD_EN
        .inForward(inForward),
`endif
        .inReady  (inReady),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product per column; row r uses coef[k] * a[(r+k) mod 4].
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit fwd);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   o;
        logic [127:0] res;
        if (fwd) begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end else begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o = o ^ gmul(coef[k], a[(rr + k) % 4]);
                res[127 - 32*c - 8*rr -: 8] = o;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic xfer(input logic [127:0] d, input bit fwd, input int hold, input bit noise,
                        output logic [127:0] res);
        int n;
        logic [127:0] snap;
        n = 0;
        while (!inReady && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 128'(inReady), 128'(1));
        inData  = d;
        inValid = 1'b1;
`ifdef AES_MIX_FWD_EN
        inForward = fwd;
`endif
        outReady = (hold == 0);
        @(posedge clk); #1;
        inValid = noise;
        inData  = noise ? rand128() : 128'd0;
        n = 0;
        while (!outValid && n < 20) begin
            check("busy_in_ready", 128'(inReady), 128'(0));
            @(posedge clk); #1; n++;
            if (noise) inData = rand128();
        end
        check("latency", 128'(n), 128'(4));
        snap = outData;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 128'(outValid), 128'(1));
            check("hold_data", outData, snap);
            check("hold_in_ready", 128'(inReady), 128'(0));
            @(posedge clk); #1;
            if (noise) inData = rand128();
        end
        outReady = 1'b1;
        check("done_valid", 128'(outValid), 128'(1));
        res = outData;
        @(posedge clk); #1;
        outReady = 1'b0;
        inValid  = 1'b0;
        check("post_valid", 128'(outValid), 128'(0));
        check("post_in_ready", 128'(inReady), 128'(1));
    endtask

    initial begin
        logic [127:0] d, f, b;
        rst      = 1'b1;
        inValid  = 1'b1;
        inData   = 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa;
        outReady = 1'b0;
`ifdef AES_MIX_FWD_EN
        inForward = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_in_ready", 128'(inReady), 128'(0));
            check("rst_out_valid", 128'(outValid), 128'(0));
            check("rst_out_data", outData, 128'd0);
        end
        inValid = 1'b0;
        rst     = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", 128'(inReady), 128'(1));
        check("rel_out_valid", 128'(outValid), 128'(0));

        xfer(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0, 0, 1'b0, f);
        check("known_vec", f, 128'hdb135345_f20a225c_01010101_d4d4d4d5);

        xfer({4{32'hc6c6c6c6}}, 1'b0, 10, 1'b0, f);
        check("c6_stall", f, {4{32'hc6c6c6c6}});

        d = rand128();
        xfer(d, 1'b0, 3, 1'b1, f);
        check("noise_ignored", f, ref_mix(d, 1'b0));

        // Abort in BUSY cycle 2, then a fresh vector must be unaffected.
        inData  = 128'hffff_0000_1234_5678_9abc_def0_0f0f_f0f0;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 128'(inReady), 128'(0));
        check("abort_out_valid", 128'(outValid), 128'(0));
        check("abort_out_data", outData, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_rel_in_ready", 128'(inReady), 128'(1));
        d = rand128();
        xfer(d, 1'b0, 0, 1'b0, f);
        check("after_abort", f, ref_mix(d, 1'b0));

        for (int i = 0; i < 200; i++) begin
            d = rand128();
            xfer(d, 1'b0, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), f);
            check("rand_inv", f, ref_mix(d, 1'b0));
        end

`ifdef AES_MIX_FWD_EN
        xfer(128'hdb135345_f20a225c_2d26314c_d4d4d4d5, 1'b1, 0, 1'b0, f);
        check("known_fwd", f, 128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6);
        for (int i = 0; i < 1000; i++) begin
            d = rand128();
            xfer(d, 1'b1, int'($urandom_range(0, 1)), 1'b0, f);
            check("rand_fwd", f, ref_mix(d, 1'b1));
            xfer(f, 1'b0, 0, 1'b0, b);
            check("round_trip", b, d);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
